// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the RV32 Memory-cycle stage: one request at a time, fixed wait-state latency.
// Optional DMEM_MISALIGN_ERR_EN flags misaligned requests on resp_err and suppresses their array access.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic                    mis_q, mis_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic                    req_misaligned;
  logic [31:0]             mem_rd;
  logic [31:0]             mem_q [WORDS];

`ifdef DMEM_MISALIGN_ERR_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

  // A single-lane load (LB/LBU at any offset) is legal; stores must be word-aligned.
  assign req_misaligned = (req_addr[1:0] != 2'b00) && (req_write || !$onehot(req_be));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign req_misaligned   = 1'b0;
`endif

  assign mem_rd     = mem_q[idx_q];
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[DEPTH_LOG2+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          mis_d   = req_misaligned;
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The access edge is the one after the counter has already reached zero.
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = mis_q;
          rdata_d = 32'h0;
          if (!mis_q) begin
            if (wr_q) mem_we  = 1'b1;
            else      rdata_d = mem_rd;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
